store_merge_buffer: RTL

//  Parametrised store path between the MEM stage and the data memory: formats byte/half/word
//  (and dword when DATA_W=64) stores into lane-aligned write data plus byte enables, queues them
//  in a DEPTH-entry FIFO and drains one entry per accepted beat over a valid/ready port.

---
 rtl/store_pkg.sv | 21 ++
 rtl/store_lane_align.sv | 51 +++++
 rtl/store_merge_buffer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the store path.
// Contents:
//   st_size_e  - encoding of the 2-bit store size field
//   BYTE_W     - bits per byte lane
//   size_bytes - number of bytes covered by a size code
package store_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } st_size_e;

  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane formatter. It turns a right-justified store into
// lane-aligned write data, byte enables and a misalignment flag.
// Ports:
//   off        in  byte offset inside the memory word
//   size       in  size code (byte/half/word/dword)
//   data       in  right-justified store data
//   byteen     out byte enables, bit i = lane i
//   wdata      out lane-aligned data; disabled lanes are zero
//   misaligned out offset not a multiple of the size, or dword on a 32-bit path
module store_lane_align
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [1:0]                  size,
  input  logic [DATA_W-1:0]           data,
  output logic [DATA_W/8-1:0]         byteen,
  output logic [DATA_W-1:0]           wdata,
  output logic                        misaligned
);

  localparam int NB = DATA_W / 8;

  logic [NB-1:0]     size_mask;
  logic [DATA_W-1:0] data_masked;
  logic [2:0]        off3;

  // Lanes below the access size are live before shifting into place.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign size_mask[gi] = (gi < size_bytes(size));
    assign data_masked[BYTE_W*gi +: BYTE_W] = data[BYTE_W*gi +: BYTE_W] & {BYTE_W{size_mask[gi]}};
  end

  // Widen the offset so the dword check indexes a fixed 3-bit vector on both widths.
  assign off3 = 3'(off);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off3[0];
      SZ_WORD: misaligned = |off3[1:0];
      default: misaligned = (NB < 8) || (|off3);
    endcase
  end

  assign byteen = size_mask << off;
  assign wdata  = data_masked << {off, 3'b000};

endmodule

// File: rtl/store_merge_buffer.sv
// Store buffer between the MEM-stage store unit and data memory.
// Formats stores into lane-aligned entries, queues up to DEPTH of them,
// merges a store into the newest entry when it hits the same word and that
// entry is not the one currently offered, and drains over valid/ready.
// Ports:
//   clk, reset (async, active-low)
//   st_valid/st_ready/st_addr/st_size/st_data  store request side
//   st_err      combinational misalignment / illegal size flag
//   flush       drop all queued entries and any store presented with it
//   mem_valid/mem_ready/mem_addr/mem_byteen/mem_wdata  head entry to memory
//   empty       no entries queued
module store_merge_buffer
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [1:0]          st_size,
  input  logic [DATA_W-1:0]   st_data,
  output logic                st_err,
  input  logic                flush,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_byteen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                empty
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [NB-1:0]     be_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0] head, tail, newest;
  logic [PW:0]   count, count_next;

  logic [NB-1:0]     al_byteen;
  logic [DATA_W-1:0] al_wdata, merged_data;
  logic              al_misaligned;
  logic [ADDR_W-1:0] word_addr;
  logic              accept, pop, push, merge_hit;

  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .off        (st_addr[OW-1:0]),
    .size       (st_size),
    .data       (st_data),
    .byteen     (al_byteen),
    .wdata      (al_wdata),
    .misaligned (al_misaligned)
  );

  assign word_addr = {st_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign newest    = tail - 1'b1;

  assign st_err    = st_valid & al_misaligned;
  assign st_ready  = (count < (PW+1)'(DEPTH));
  assign mem_valid = (count != '0);
  assign empty     = (count == '0);
  assign mem_addr   = addr_mem[head];
  assign mem_byteen = be_mem[head];
  assign mem_wdata  = data_mem[head];

  assign accept = st_valid & st_ready & ~al_misaligned & ~flush;
  assign pop    = mem_valid & mem_ready;
  // With a single entry the newest is the head being offered, so it must not change.
  assign merge_hit = accept && (count >= (PW+1)'(2)) && (addr_mem[newest] == word_addr);
  assign push   = accept & ~merge_hit;

  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign merged_data[BYTE_W*gi +: BYTE_W] = al_byteen[gi] ? al_wdata[BYTE_W*gi +: BYTE_W]
                                                            : data_mem[newest][BYTE_W*gi +: BYTE_W];
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        be_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        addr_mem[tail] <= word_addr;
        be_mem[tail]   <= al_byteen;
        data_mem[tail] <= al_wdata;
        tail           <= tail + 1'b1;
      end
      if (merge_hit) begin
        be_mem[newest]   <= be_mem[newest] | al_byteen;
        data_mem[newest] <= merged_data;
      end
      if (pop) head <= head + 1'b1;
      count <= count_next;
    end
  end

endmodule
